// File: rtl/panel_keys_pkg.sv
// panel_keys_pkg: shared definitions for the console front-panel input stage.
//   - console command codes, which the CPU console-command decoder also uses
//   - KEY bit indices and switch/key counts
//   - holding-register FSM states
//   - priority pick of simultaneous key presses
package panel_keys_pkg;

    localparam int unsigned CMD_W    = 3;
    localparam int unsigned NUM_SW   = 12;
    localparam int unsigned NUM_KEYS = 6;

    localparam int unsigned KEY_START    = 0;
    localparam int unsigned KEY_STOP     = 1;
    localparam int unsigned KEY_CONTINUE = 2;
    localparam int unsigned KEY_LOADADDR = 3;
    localparam int unsigned KEY_DEPOSIT  = 4;
    localparam int unsigned KEY_EXAMINE  = 5;

    typedef enum logic [CMD_W-1:0] {
        CMD_NONE     = 3'd0,
        CMD_START    = 3'd1,
        CMD_STOP     = 3'd2,
        CMD_CONTINUE = 3'd3,
        CMD_LOADADDR = 3'd4,
        CMD_DEPOSIT  = 3'd5,
        CMD_EXAMINE  = 3'd6
    } cmd_e;

    typedef enum logic {
        StIdle,
        StPending
    } state_e;

    // STOP outranks START so that an operator can always halt the machine.
    function automatic cmd_e pick_cmd(input logic [NUM_KEYS-1:0] press);
        cmd_e c;
        if (press[KEY_STOP])          c = CMD_STOP;
        else if (press[KEY_START])    c = CMD_START;
        else if (press[KEY_CONTINUE]) c = CMD_CONTINUE;
        else if (press[KEY_LOADADDR]) c = CMD_LOADADDR;
        else if (press[KEY_DEPOSIT])  c = CMD_DEPOSIT;
        else if (press[KEY_EXAMINE])  c = CMD_EXAMINE;
        else                          c = CMD_NONE;
        return c;
    endfunction

    // True when more than one press bit is set (clearing the lowest set bit leaves something).
    function automatic logic multi_press(input logic [NUM_KEYS-1:0] press);
        return (press & (press - NUM_KEYS'(1))) != '0;
    endfunction

endpackage

// File: rtl/panel_keys_debounce_bit.sv
// panel_keys_debounce_bit: one front-panel input bit.
//   Two-flop synchroniser, then a sample history advanced on each tick. The
//   output flips only after four agreeing tick samples.
// Ports:
//   clk_i   system clock
//   rst_i   asynchronous active-high reset
//   tick_i  sample enable, one cycle wide
//   raw_i   raw asynchronous input
//   deb_o   debounced level
module panel_keys_debounce_bit (
    input  logic clk_i,
    input  logic rst_i,
    input  logic tick_i,
    input  logic raw_i,
    output logic deb_o
);

    logic       sync1_q, sync2_q;
    logic [2:0] hist_q, hist_d;
    logic       deb_q, deb_d;

    // The 3 stored samples plus the sample being taken form the 4-deep window.
    always_comb begin
        hist_d = hist_q;
        deb_d  = deb_q;
        if (tick_i) begin
            hist_d = {hist_q[1:0], sync2_q};
            if ((&hist_q) && sync2_q) begin
                deb_d = 1'b1;
            end else if (!(|hist_q) && !sync2_q) begin
                deb_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= '0;
            deb_q   <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            hist_q  <= hist_d;
            deb_q   <= deb_d;
        end
    end

    assign deb_o = deb_q;

endmodule

// File: rtl/panel_keys.sv
// panel_keys: PDP-8 console front-panel input stage.
//   Debounces 12 switch-register toggles and 6 console keys, presents the
//   switch register, and turns key presses into console commands held in a
//   single-entry register drained by a valid/ready handshake.
// Ports:
//   CLK       system clock
//   RESET     asynchronous active-high reset
//   SW        raw switch register toggles
//   KEY       raw keys [0]START [1]STOP [2]CONTINUE [3]LOADADDR [4]DEPOSIT [5]EXAMINE
//   sr        debounced switch register (also the panel's yellow row)
//   cmd       console command code
//   cmdValid  cmd is valid
//   cmdReady  CPU accepts cmd this cycle
//   dropped   one-cycle pulse when a key press is discarded
module panel_keys
    import panel_keys_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1000
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NUM_SW-1:0] SW,
    input  logic [NUM_KEYS-1:0] KEY,
    output logic [NUM_SW-1:0] sr,
    output logic [CMD_W-1:0]  cmd,
    output logic              cmdValid,
    input  logic              cmdReady,
    output logic              dropped
);

    localparam int unsigned NumBits = NUM_SW + NUM_KEYS;
    localparam int unsigned CntW    = $clog2(TICK_DIV);
    localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                tick;
    logic [NumBits-1:0]  raw, deb;
    logic [NUM_KEYS-1:0] deb_key, key_prev_q, press;
    state_e              state_q, state_d;
    cmd_e                cmd_q, cmd_d, win_cmd;
    logic                valid_q, valid_d;
    logic                dropped_q, dropped_d;
    logic                multi;

    // Sample tick
    assign tick  = (cnt_q == CntMax);
    assign cnt_d = tick ? '0 : cnt_q + CntW'(1);

    // Debounce all inputs; keys sit above the switches.
    assign raw = {KEY, SW};

    for (genvar i = 0; i < NumBits; i++) begin : g_bit
        panel_keys_debounce_bit u_bit (
            .clk_i  (CLK),
            .rst_i  (RESET),
            .tick_i (tick),
            .raw_i  (raw[i]),
            .deb_o  (deb[i])
        );
    end

    assign deb_key = deb[NumBits-1:NUM_SW];
    assign press   = deb_key & ~key_prev_q;
    assign win_cmd = pick_cmd(press);
    assign multi   = multi_press(press);

    // Holding register
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        valid_d   = valid_q;
        dropped_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (|press) begin
                    state_d   = StPending;
                    cmd_d     = win_cmd;
                    valid_d   = 1'b1;
                    dropped_d = multi;
                end
            end
            StPending: begin
                if (cmdReady) begin
                    // Anything pressed on the accepting edge is lost.
                    state_d   = StIdle;
                    cmd_d     = CMD_NONE;
                    valid_d   = 1'b0;
                    dropped_d = |press;
                end else if (press[KEY_STOP] && (cmd_q != CMD_STOP)) begin
                    // STOP pre-empts whatever is waiting; only other keys count as dropped.
                    cmd_d     = CMD_STOP;
                    dropped_d = multi;
                end else begin
                    dropped_d = |press;
                end
            end
            default: begin
                state_d = StIdle;
                cmd_d   = CMD_NONE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt_q      <= '0;
            key_prev_q <= '0;
            state_q    <= StIdle;
            cmd_q      <= CMD_NONE;
            valid_q    <= 1'b0;
            dropped_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            key_prev_q <= deb_key;
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            valid_q    <= valid_d;
            dropped_q  <= dropped_d;
        end
    end

    assign sr       = deb[NUM_SW-1:0];
    assign cmd      = cmd_q;
    assign cmdValid = valid_q;
    assign dropped  = dropped_q;

endmodule

// File: tb/tb_panel_keys.sv
// tb_panel_keys: directed bench for panel_keys with TICK_DIV=4.
//   A behavioural model (sample windows per tick, a pending flag and code)
//   is compared with the DUT on every falling edge; directed scenarios add
//   hand-computed literal expectations.
module tb_panel_keys;

    localparam int unsigned TD = 4;

    logic        CLK;
    logic        RESET;
    logic [11:0] SW;
    logic [5:0]  KEY;
    logic [11:0] sr;
    logic [2:0]  cmd;
    logic        cmdValid;
    logic        cmdReady;
    logic        dropped;

    int n_tests;
    int n_fail;

    panel_keys #(
        .TICK_DIV (TD)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .SW       (SW),
        .KEY      (KEY),
        .sr       (sr),
        .cmd      (cmd),
        .cmdValid (cmdValid),
        .cmdReady (cmdReady),
        .dropped  (dropped)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- behavioural model ----------------
    logic [17:0] m_r1, m_r2, m_deb, m_deb_prev;
    logic [17:0] m_win [4];
    int          m_edge;
    bit          m_pend;
    int          m_code;
    bit          m_drop;

    initial begin : model
        logic [5:0] pr;
        int         nprs;
        int         win;
        int         order [6];
        int         ones;
        order = '{1, 0, 2, 3, 4, 5};  // STOP, START, CONTINUE, LOADADDR, DEPOSIT, EXAMINE
        forever begin
            @(posedge CLK or posedge RESET);
            if (RESET) begin
                m_r1 = '0; m_r2 = '0; m_deb = '0; m_deb_prev = '0;
                for (int i = 0; i < 4; i++) m_win[i] = '0;
                m_edge = 0; m_pend = 0; m_code = 0; m_drop = 0;
            end else begin
                pr   = m_deb[17:12] & ~m_deb_prev[17:12];
                nprs = $countones(pr);
                win  = 0;
                for (int j = 0; j < 6; j++) begin
                    if (pr[order[j]] && win == 0) win = order[j] + 1;
                end
                if (!m_pend) begin
                    if (nprs > 0) begin
                        m_pend = 1; m_code = win; m_drop = (nprs > 1);
                    end else begin
                        m_drop = 0;
                    end
                end else if (cmdReady) begin
                    m_pend = 0; m_code = 0; m_drop = (nprs > 0);
                end else if (pr[1] && m_code != 2) begin
                    m_code = 2; m_drop = (nprs > 1);
                end else begin
                    m_drop = (nprs > 0);
                end
                m_deb_prev = m_deb;
                m_edge++;
                if (m_edge % TD == 0) begin
                    for (int i = 3; i > 0; i--) m_win[i] = m_win[i-1];
                    m_win[0] = m_r2;
                    for (int b = 0; b < 18; b++) begin
                        ones = 0;
                        for (int i = 0; i < 4; i++) ones += int'(m_win[i][b]);
                        if (ones == 4) m_deb[b] = 1'b1;
                        else if (ones == 0) m_deb[b] = 1'b0;
                    end
                end
                m_r2 = m_r1;
                m_r1 = {KEY, SW};
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wait_valid(input string name, output int drops);
        bit seen;
        seen  = 0;
        drops = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge CLK);
            if (dropped) drops++;
            if (cmdValid) seen = 1;
        end
        check({name, "_valid_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic accept(input string name);
        @(posedge CLK); #1;
        cmdReady = 1'b1;
        @(posedge CLK); #1;
        cmdReady = 1'b0;
        @(negedge CLK);
        check({name, "_valid_after_accept"}, 32'(cmdValid), 32'd0);
    endtask

    // ---------------- stimulus + compare ----------------
    initial begin
        int  d;
        bit  seen;
        n_tests  = 0;
        n_fail   = 0;
        RESET    = 1'b1;
        SW       = '0;
        KEY      = '0;
        cmdReady = 1'b0;
        fork
            begin : cmp
                forever begin
                    @(negedge CLK);
                    check("model_sr",       32'(sr),       32'(m_deb[11:0]));
                    check("model_cmd",      32'(cmd),      32'(m_code));
                    check("model_cmdValid", 32'(cmdValid), 32'(m_pend));
                    check("model_dropped",  32'(dropped),  32'(m_drop));
                end
            end
            begin : stim
                // Reset state
                repeat (3) @(posedge CLK);
                @(negedge CLK);
                check("rst_sr", 32'(sr), 32'd0);
                check("rst_cmd", 32'(cmd), 32'd0);
                check("rst_valid", 32'(cmdValid), 32'd0);
                check("rst_dropped", 32'(dropped), 32'd0);
                step(1);
                RESET = 1'b0;

                // Stable switch pattern
                SW = 12'o5252;
                step(18);
                @(negedge CLK);
                check("sr_5252", 32'(sr), 32'o5252);
                check("sw_no_cmd", 32'(cmdValid), 32'd0);

                // SW[3] low, then bounce, then settle high
                step(1);
                SW = 12'o5242;
                step(18);
                @(negedge CLK);
                check("sr_5242", 32'(sr), 32'o5242);
                for (int i = 0; i < 40; i++) begin
                    @(posedge CLK); #1;
                    SW[3] = ((i / 3) % 2) == 0;
                    @(negedge CLK);
                    check("bounce_sr3", 32'(sr[3]), 32'd0);
                end
                @(posedge CLK); #1;
                SW[3] = 1'b1;
                step(18);
                @(negedge CLK);
                check("settle_sr", 32'(sr), 32'o5252);

                // DEPOSIT held pending, then accepted; release yields nothing
                step(1);
                KEY = 6'b010000;
                wait_valid("dep", d);
                check("dep_cmd", 32'(cmd), 32'd5);
                check("dep_drops", 32'(d), 32'd0);
                for (int i = 0; i < 50; i++) begin
                    @(negedge CLK);
                    check("dep_hold_cmd", 32'(cmd), 32'd5);
                    check("dep_hold_valid", 32'(cmdValid), 32'd1);
                end
                accept("dep");
                step(1);
                KEY = '0;
                for (int i = 0; i < 30; i++) begin
                    @(negedge CLK);
                    check("release_no_cmd", 32'(cmdValid), 32'd0);
                end

                // START + EXAMINE together
                step(1);
                KEY = 6'b100001;
                wait_valid("se", d);
                check("se_cmd", 32'(cmd), 32'd1);
                check("se_drops", 32'(d), 32'd1);
                accept("se");
                for (int i = 0; i < 30; i++) begin
                    @(negedge CLK);
                    check("se_no_examine", 32'(cmdValid), 32'd0);
                    check("se_no_drop", 32'(dropped), 32'd0);
                end
                step(1);
                KEY = '0;
                step(30);

                // DEPOSIT pending, EXAMINE dropped, STOP replaces
                KEY = 6'b010000;
                wait_valid("pend", d);
                check("pend_cmd", 32'(cmd), 32'd5);
                step(1);
                KEY = 6'b110000;
                seen = 0;
                for (int i = 0; i < 30 && !seen; i++) begin
                    @(negedge CLK);
                    if (dropped) seen = 1;
                end
                check("exam_dropped_seen", 32'(seen), 32'd1);
                check("exam_cmd_kept", 32'(cmd), 32'd5);
                check("exam_valid_kept", 32'(cmdValid), 32'd1);
                step(1);
                KEY = 6'b110010;
                seen = 0;
                d = 0;
                for (int i = 0; i < 30 && !seen; i++) begin
                    @(negedge CLK);
                    if (dropped) d++;
                    if (cmd == 3'd2) seen = 1;
                end
                check("stop_replace_seen", 32'(seen), 32'd1);
                check("stop_no_drop", 32'(d), 32'd0);
                check("stop_valid", 32'(cmdValid), 32'd1);
                accept("stop");
                step(1);
                KEY = '0;
                step(30);

                // Reset while pending with START held
                KEY = 6'b000001;
                wait_valid("prerst", d);
                check("prerst_cmd", 32'(cmd), 32'd1);
                @(posedge CLK); #2;
                RESET = 1'b1;
                #1;
                check("rst_async_valid", 32'(cmdValid), 32'd0);
                check("rst_async_cmd", 32'(cmd), 32'd0);
                check("rst_async_sr", 32'(sr), 32'd0);
                step(2);
                RESET = 1'b0;
                wait_valid("postrst", d);
                check("postrst_cmd", 32'(cmd), 32'd1);
                accept("postrst");
                step(1);
                KEY = '0;
                step(30);
            end
        join_any
        disable fork;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/panel_keys.md
# panel_keys

Front-panel input stage for the PDP-8 console: synchronises and debounces the 12 switch-register toggles and 6 momentary console keys. Presents the debounced switch register to the CPU and to the LED panel (yellow row). Converts key presses into single console commands, handed to the CPU control unit over a valid/ready handshake. Sits directly upstream of the multiplexed LED panel driver and beside the CPU's console-command decoder.

## Interface
- TICK_DIV, 1000: clock cycles per debounce sample tick (≥2).
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- SW  in  12  raw switch-register toggles, active-high, asynchronous to CLK.
- KEY  in  6  raw keys, active-high: [0]START [1]STOP [2]CONTINUE [3]LOADADDR [4]DEPOSIT [5]EXAMINE.
- sr  out  12  debounced switch register; also feeds the panel's yellow row.
- cmd  out  3  console command code (shared package encoding).
- cmdValid  out  1  cmd is valid.
- cmdReady  in  1  CPU accepts cmd this cycle.
- dropped  out  1  one-cycle pulse when a key press is discarded.

## Operation
- Reset values: sr=0, cmd=CMD_NONE(0), cmdValid=0, dropped=0; all synchroniser, history and debounced bits 0; tick counter 0.
- Every input bit passes through a 2-flop synchroniser.
- Tick counter counts 0..TICK_DIV-1 and wraps. It asserts tick for one cycle when the count equals TICK_DIV-1.
- On tick, each of the 18 bits shifts its synchronised value into a 4-deep history.
- Debounced bit goes to 1 when the previous 3 history bits and the new sample are all 1, and to 0 when all 4 are 0. Otherwise it holds.
- sr equals the debounced SW bits.
- A press is a debounced KEY bit rising 0→1. Releases generate nothing.
- Command encoding: NONE=0, START=1, STOP=2, CONTINUE=3, LOADADDR=4, DEPOSIT=5, EXAMINE=6.
- If several presses are detected on the same tick, priority is STOP > START > CONTINUE > LOADADDR > DEPOSIT > EXAMINE. Lower-priority presses are discarded, and dropped pulses once.
- Single-entry holding register, two states:
  - IDLE: cmdValid=0, cmd=NONE. A winning press loads cmd and moves to PENDING.
  - PENDING: cmdValid=1 and cmd stays stable until cmdValid&cmdReady, then return to IDLE.
- A press detected while PENDING, or on the same edge as the accepting handshake, is discarded with a dropped pulse. Exception: STOP while PENDING with a non-STOP cmd replaces cmd with STOP and does not pulse dropped.
- cmdReady is ignored while cmdValid=0.
- RESET asserted at any time returns everything to reset values immediately. A pending command is lost.
- Keys held through reset release produce a press after debounce, because the debounced state restarts at 0.

## Timing
- tick occurs every TICK_DIV cycles. The first tick is TICK_DIV cycles after reset release.
- The debounced bit updates on the tick edge that takes the 4th agreeing sample.
- sr changes on that same edge.
- cmdValid rises one edge after the debounced key rises.
- Raw-to-sr latency: 2 sync cycles plus 3 to 4 ticks, so at most 2 + 4·TICK_DIV cycles.
- The handshake completes on the edge where cmdValid&cmdReady. cmdValid is low in the following cycle.
- The fastest back-to-back commands are separated by at least one tick.
- dropped is high for exactly one cycle, aligned with the edge the press was evaluated.

## Structure
- Shared package: command codes CMD_NONE..CMD_EXAMINE, KEY bit indices, command width (3).
- Sub-module debounce_bit: 2-flop sync, 4-sample history and debounced output, with a tick enable. Instantiate it 18 times via generate.
- Top level holds the tick counter, edge detect, priority encoder and the holding FSM.

## Test plan
- Reset, TICK_DIV=4: all outputs 0. Set SW=12'o5252 stable → sr=12'o5252 within 18 cycles, and cmdValid stays 0.
- SW[3] bounces 0/1 every 3 cycles for 40 cycles, then settles at 1 → sr[3] never toggles during the bounce and reaches 1 within 18 cycles of settling.
- Press DEPOSIT with cmdReady=0 → cmd=5, cmdValid=1, held stable for 50 cycles. Pulse cmdReady → cmdValid=0 the next cycle. Releasing the key produces no command.
- Press START and EXAMINE on the same tick → cmd=1, dropped pulses once. Accept; no EXAMINE follows.
- With DEPOSIT pending, press EXAMINE → dropped pulse, cmd stays 5. Then press STOP → cmd becomes 2, no dropped pulse.
- Assert RESET while PENDING with a key held → cmdValid=0 immediately. After release, the held key yields a new command after debounce.
